// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache, plus its perf counters.
// The cache takes the slave modport; the fetch stage / memory model takes master.
interface instruction_cache_if #(
  parameter int CNT_W = 32
);
  logic             cpu_req;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_instr;
  logic             cpu_stall;
  logic             flush;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_instr;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_instr,
    output cpu_instr, cpu_stall, mem_addr, hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_instr,
    input  cpu_instr, cpu_stall, mem_addr, hit_count, miss_count
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache: same-cycle hits, miss stalls fetch for LINE_WORDS+1 cycles
// while the line is refilled word 0 upward from a zero-latency memory; flush invalidates all lines.
module instruction_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 16,
  parameter int CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instruction_cache_if.slave   bus
);
  localparam int OFF   = $clog2(LINE_WORDS);
  localparam int IDX   = $clog2(NUM_LINES);
  localparam int TAG_W = 32 - OFF - IDX - 2;
  localparam logic [31:0]    NOP      = 32'h0000_0013;
  localparam logic [OFF-1:0] LAST_CNT = OFF'(LINE_WORDS - 1);

  typedef enum logic {ST_IDLE, ST_REFILL} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [31:0]          r_data [NUM_LINES][LINE_WORDS];
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [OFF-1:0]       r_cnt;
  logic [TAG_W-1:0]     r_miss_tag;
  logic [IDX-1:0]       r_miss_idx;
  logic [CNT_W-1:0]     r_hit_count;
  logic [CNT_W-1:0]     r_miss_count;

  logic [OFF-1:0]   w_off;
  logic [IDX-1:0]   w_idx;
  logic [TAG_W-1:0] w_tag;
  logic             w_lookup;
  logic             w_hit;
  logic             w_miss;
  logic             w_last;
  logic             w_stall;
  logic [31:0]      w_instr;
  logic [31:0]      w_mem_addr;
  logic             w_addr_unused;

  assign w_off         = bus.cpu_addr[OFF+1:2];
  assign w_idx         = bus.cpu_addr[OFF+IDX+1:OFF+2];
  assign w_tag         = bus.cpu_addr[31:OFF+IDX+2];
  assign w_addr_unused = &{1'b0, bus.cpu_addr[1:0]};

  assign w_lookup = (r_state == ST_IDLE) && bus.cpu_req;
  assign w_hit    = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss   = w_lookup && !w_hit;
  assign w_last   = (r_cnt == LAST_CNT);

  always_comb begin
    w_next_state = r_state;
    w_stall      = 1'b0;
    w_instr      = NOP;
    w_mem_addr   = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_instr = r_data[w_idx][w_off];
        end else if (w_miss) begin
          w_stall = 1'b1;
          if (!bus.flush) w_next_state = ST_REFILL;
        end
      end
      ST_REFILL: begin
        w_stall    = 1'b1;
        w_mem_addr = {r_miss_tag, r_miss_idx, r_cnt, 2'b00};
        if (bus.flush || w_last) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Async reset must quiet the fetch interface immediately, not at the next edge.
    if (!rst_n) begin
      w_stall    = 1'b0;
      w_instr    = NOP;
      w_mem_addr = 32'd0;
    end
  end

  assign bus.cpu_stall  = w_stall;
  assign bus.cpu_instr  = w_instr;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_valid      <= '0;
      r_cnt        <= '0;
      r_miss_tag   <= '0;
      r_miss_idx   <= '0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_hit)  r_hit_count  <= r_hit_count + 1'b1;
      if (w_miss) begin
        r_miss_count      <= r_miss_count + 1'b1;
        r_miss_tag        <= w_tag;
        r_miss_idx        <= w_idx;
        r_cnt             <= '0;
        r_valid[w_idx]    <= 1'b0;
      end
      if (r_state == ST_REFILL) begin
        r_cnt <= (bus.flush || w_last) ? '0 : r_cnt + 1'b1;
        if (w_last && !bus.flush) r_valid[r_miss_idx] <= 1'b1;
      end
      // Flush wins over any install or invalidate above.
      if (bus.flush) r_valid <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_REFILL) begin
      r_data[r_miss_idx][r_cnt] <= bus.mem_instr;
      if (w_last && !bus.flush) r_tag[r_miss_idx] <= r_miss_tag;
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Directed scenarios plus randomized fetch/flush traffic checked against a line-level cache model.
module tb_instruction_cache;
  localparam int          LW   = 4;
  localparam int          NL   = 16;
  localparam int          LB   = LW * 4;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_cache_if #(.CNT_W(32)) bus ();

  instruction_cache #(.LINE_WORDS(LW), .NUM_LINES(NL), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0)      return 32'h00A0_0093;
    else if (a == 32'h4) return 32'h0640_2223;
    else                 return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.mem_instr = mem_word(bus.mem_addr);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Line-granular model: which line base address each index holds, and a refill countdown.
  bit          m_valid [NL];
  logic [31:0] m_tag   [NL];
  int          m_left;
  logic [31:0] m_base;
  logic [31:0] m_hits, m_misses;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / LB) % NL);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] a);
    return a / (LB * NL);
  endfunction

  function automatic bit m_hit();
    return (m_left == 0) && bus.cpu_req && m_valid[idx_of(bus.cpu_addr)]
           && (m_tag[idx_of(bus.cpu_addr)] == tag_of(bus.cpu_addr));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) m_valid[i] <= 1'b0;
      m_left   <= 0;
      m_base   <= '0;
      m_hits   <= '0;
      m_misses <= '0;
    end else begin
      if (m_left == 0) begin
        if (bus.cpu_req) begin
          if (m_hit()) m_hits <= m_hits + 1;
          else begin
            m_misses <= m_misses + 1;
            m_valid[idx_of(bus.cpu_addr)] <= 1'b0;
            if (!bus.flush) begin
              m_left <= LW;
              m_base <= bus.cpu_addr & ~32'(LB - 1);
            end
          end
        end
      end else if (bus.flush) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid[idx_of(m_base)] <= 1'b1;
          m_tag[idx_of(m_base)]   <= tag_of(m_base);
        end
      end
      if (bus.flush) for (int i = 0; i < NL; i++) m_valid[i] <= 1'b0;
    end
  end

  always @(negedge clk) begin
    logic        e_stall;
    logic [31:0] e_instr, e_maddr;
    e_stall = 1'b0;
    e_instr = NOP;
    e_maddr = 32'd0;
    if (rst_n) begin
      if (m_left > 0) begin
        e_stall = 1'b1;
        e_maddr = m_base + 32'(4 * (LW - m_left));
      end else if (bus.cpu_req) begin
        if (m_hit()) e_instr = mem_word(bus.cpu_addr & ~32'h3);
        else         e_stall = 1'b1;
      end
    end
    chk("model_stall", {31'd0, bus.cpu_stall}, {31'd0, e_stall});
    chk("model_instr", bus.cpu_instr, e_instr);
    chk("model_mem_addr", bus.mem_addr, e_maddr);
    chk("model_hit_count", bus.hit_count, m_hits);
    chk("model_miss_count", bus.miss_count, m_misses);
  end

  logic [31:0] first_ma, last_ma;

  // Inputs are already applied; counts stall cycles until the fetch is served.
  task automatic run_fetch(output int cyc);
    cyc = 0;
    #1;
    while (bus.cpu_stall === 1'b1 && cyc < 50) begin
      if (cyc == 1) first_ma = bus.mem_addr;
      last_ma = bus.mem_addr;
      cyc++;
      @(posedge clk); #2;
    end
    if (cyc >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL stall_timeout: still stalled after %0d cycles", cyc);
    end
  endtask

  initial begin
    int          cyc;
    logic [31:0] h0, m0;
    logic [31:0] ma [4];

    rst_n        = 1'b0;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = 32'd0;
    bus.flush    = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("reset_instr", bus.cpu_instr, NOP);
    chk("reset_mem_addr", bus.mem_addr, 32'd0);
    chk("reset_hits", bus.hit_count, 32'd0);
    chk("reset_misses", bus.miss_count, 32'd0);
    rst_n = 1'b1;

    // T1 cold miss
    @(posedge clk); #2;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h0;
    cyc = 0;
    #1;
    while (bus.cpu_stall === 1'b1 && cyc < 50) begin
      if (cyc >= 1 && cyc <= 4) ma[cyc-1] = bus.mem_addr;
      cyc++;
      @(posedge clk); #2;
    end
    chk("t1_stall_cycles", 32'(cyc), 32'd5);
    chk("t1_mem_addr0", ma[0], 32'h0);
    chk("t1_mem_addr1", ma[1], 32'h4);
    chk("t1_mem_addr2", ma[2], 32'h8);
    chk("t1_mem_addr3", ma[3], 32'hC);
    chk("t1_instr", bus.cpu_instr, 32'h00A0_0093);
    chk("t1_misses", bus.miss_count, 32'd1);
    @(posedge clk); #1;
    chk("t1_hits", bus.hit_count, 32'd1);

    // T2 hit in filled line
    bus.cpu_addr = 32'h4;
    #1;
    chk("t2_instr", bus.cpu_instr, 32'h0640_2223);
    chk("t2_stall", {31'd0, bus.cpu_stall}, 32'd0);
    @(posedge clk); #2;
    chk("t2_hits", bus.hit_count, 32'd2);

    // T3 conflict on index 0
    bus.cpu_addr = 32'h100;
    run_fetch(cyc);
    chk("t3_stall_cycles", 32'(cyc), 32'd5);
    chk("t3_first_mem_addr", first_ma, 32'h100);
    chk("t3_last_mem_addr", last_ma, 32'h10C);
    bus.cpu_addr = 32'h0;
    run_fetch(cyc);
    chk("t3_refetch_cycles", 32'(cyc), 32'd5);
    chk("t3_misses", bus.miss_count, 32'd3);

    // T4 flush on the second refill cycle
    bus.cpu_addr = 32'h200;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("t4_refill2_mem_addr", bus.mem_addr, 32'h204);
    bus.flush = 1'b1;
    @(posedge clk); #2;
    bus.flush = 1'b0;
    #1;
    chk("t4_after_flush_stall", {31'd0, bus.cpu_stall}, 32'd1);
    chk("t4_after_flush_mem_addr", bus.mem_addr, 32'd0);
    run_fetch(cyc);
    chk("t4_refetch_cycles", 32'(cyc), 32'd5);
    chk("t4_refill_from_word0", first_ma, 32'h200);

    // T5 async reset mid-refill
    bus.cpu_addr = 32'h300;
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t5_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("t5_hits", bus.hit_count, 32'd0);
    chk("t5_misses", bus.miss_count, 32'd0);
    chk("t5_mem_addr", bus.mem_addr, 32'd0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    bus.cpu_addr = 32'h200;
    run_fetch(cyc);
    chk("t5_post_reset_miss_cycles", 32'(cyc), 32'd5);

    // T6 idle
    bus.cpu_req = 1'b0;
    h0 = bus.hit_count;
    m0 = bus.miss_count;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      chk("t6_stall", {31'd0, bus.cpu_stall}, 32'd0);
      chk("t6_mem_addr", bus.mem_addr, 32'd0);
      chk("t6_hits", bus.hit_count, h0);
      chk("t6_misses", bus.miss_count, m0);
    end
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h208;
    #1;
    chk("t6_still_valid_stall", {31'd0, bus.cpu_stall}, 32'd0);
    chk("t6_still_valid_instr", bus.cpu_instr, mem_word(32'h208));

    // Randomized traffic over a few conflicting tags
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.cpu_req  = ($urandom_range(0, 9) < 8);
      bus.cpu_addr = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                      2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      bus.flush    = ($urandom_range(0, 99) < 3);
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    bus.flush   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
